uart_in_wb_controller: RTL

//  Sequences the `in` instruction against the register-file write port. Buffers UART RX bytes in
//  a small FIFO, assembles a byte or 32-bit word on request, stalls the PC until data is ready,

---
 rtl/uart_in_wb_controller.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_in_wb_controller.sv
// uart_in_wb_controller: sequences the `in` instruction against the register-file write port.
// UART RX bytes are buffered in a small FIFO, assembled into a byte or big-endian 32-bit word
// on request, and committed through the single RF write port once the pipeline leaves it idle.
// The PC is held while the request is outstanding.
// Optional feature: define UART_IN_TIMEOUT_EN to abandon a stalled COLLECT after
// TIMEOUT_CYCLES cycles without a byte; missing low bytes are zero and `timeout` becomes sticky.
module uart_in_wb_controller #(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  input  logic                      req,
  input  logic                      req_word,
  input  logic [REG_ADDR_WIDTH-1:0] req_rd,
  input  logic                      wb_en,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic [31:0]               wb_data,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [31:0]               rf_wdata,
  output logic                      pc_enable,
  output logic                      busy,
  output logic                      overflow,
  output logic                      timeout
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StCollect, StWrite} state_e;

  state_e                    state_q;
  logic [7:0]                fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]           fifo_cnt_q;
  logic [31:0]               assembly_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic                      word_q;
  logic [1:0]                byte_cnt_q;
  logic                      overflow_q;

  logic fifo_empty, fifo_full, pop, push, last_byte;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == CntW'(FIFO_DEPTH));
  assign pop        = (state_q == StCollect) && !fifo_empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
  assign push       = rx_valid && (!fifo_full || pop);
  assign last_byte  = word_q ? (byte_cnt_q == 2'd3) : 1'b1;

`ifdef UART_IN_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_cnt_q;
  logic            timeout_q;
  logic [5:0]      fill_shift;

  // Bits of zero padding for the bytes still missing when the timeout fires.
  assign fill_shift = word_q ? {3'd4 - {1'b0, byte_cnt_q}, 3'b000} : 6'd8;
  assign timeout    = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign overflow = overflow_q;
  assign busy     = (state_q != StIdle);

  // FIFO storage; contents need no reset since the count gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= rx_data;
  end

  // FIFO bookkeeping and request sequencing FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      assembly_q <= '0;
      rd_q       <= '0;
      word_q     <= 1'b0;
      byte_cnt_q <= 2'd0;
      overflow_q <= 1'b0;
`ifdef UART_IN_TIMEOUT_EN
      tmo_cnt_q  <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
      else if (pop && !push) fifo_cnt_q <= fifo_cnt_q - 1'b1;
      if (rx_valid && !push) overflow_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (req) begin
            rd_q       <= req_rd;
            word_q     <= req_word;
            byte_cnt_q <= 2'd0;
            assembly_q <= '0;
`ifdef UART_IN_TIMEOUT_EN
            tmo_cnt_q  <= '0;
`endif
            state_q    <= StCollect;
          end
        end
        StCollect: begin
          if (pop) begin
            // First byte received ends up most significant.
            assembly_q <= {assembly_q[23:0], fifo_mem[rd_ptr_q]};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (last_byte) state_q <= StWrite;
`ifdef UART_IN_TIMEOUT_EN
            tmo_cnt_q  <= '0;
          end else if (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
            assembly_q <= assembly_q << fill_shift;
            timeout_q  <= 1'b1;
            state_q    <= StWrite;
          end else begin
            tmo_cnt_q  <= tmo_cnt_q + 1'b1;
`endif
          end
        end
        StWrite: begin
          if (!wb_en) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // RF port arbitration and PC stall; pipeline writeback always wins.
  always_comb begin
    rf_we     = wb_en;
    rf_waddr  = wb_rd;
    rf_wdata  = wb_data;
    pc_enable = 1'b1;
    unique case (state_q)
      StIdle:    pc_enable = !req;
      StCollect: pc_enable = 1'b0;
      StWrite: begin
        if (wb_en) begin
          pc_enable = 1'b0;
        end else begin
          rf_we     = 1'b1;
          rf_waddr  = rd_q;
          rf_wdata  = assembly_q;
          pc_enable = 1'b1;
        end
      end
      default: pc_enable = 1'b1;
    endcase
  end

endmodule
